// File: rtl/matrix_compute_engine.sv
// rtl/matrix_compute_engine.sv - signed matrix ADD/MUL/TRANSPOSE/SCALAR engine over BRAM
// Fetches operands one read per cycle and streams row-major results over valid/ready.
module matrix_compute_engine #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 11,
  parameter int MAX_DIM       = 5,
  parameter int ACC_WIDTH     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               op,
  input  logic [ADDR_WIDTH-1:0]    a_base,
  input  logic [ADDR_WIDTH-1:0]    b_base,
  input  logic [3:0]               a_m,
  input  logic [3:0]               a_n,
  input  logic [3:0]               b_m,
  input  logic [3:0]               b_n,
  input  logic [ELEMENT_WIDTH-1:0] scalar,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_WIDTH-1:0]     res_data,
  output logic                     res_last,
  output logic [3:0]               res_m,
  output logic [3:0]               res_n,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error_code
);
  localparam int PW = 2 * ELEMENT_WIDTH;
  localparam logic [1:0] OP_ADD = 2'd0, OP_MUL = 2'd1, OP_TRN = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_OUTPUT, S_DONE, S_ERROR} state_t;
  state_t state, state_nxt;

  logic [1:0]                      op_q, chk_code;
  logic [ADDR_WIDTH-1:0]           a_base_q, b_base_q, rd_addr_c;
  logic [3:0]                      a_m_q, a_n_q, b_m_q, b_n_q, row, col;
  logic signed [ELEMENT_WIDTH-1:0] scalar_q, a_hold;
  logic [5:0]                      cnt, reads;
  logic signed [ACC_WIDTH-1:0]     acc, data_ext;
  logic signed [PW-1:0]            mul_prod, scl_prod;

  function automatic logic dim_bad(input logic [3:0] d);
    return (d == 4'd0) || (int'(d) > MAX_DIM);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [3:0] i, input logic [3:0] n,
                                                    input logic [3:0] j);
    logic [7:0] off;
    off = ({4'd0, i} * {4'd0, n}) + {4'd0, j};
    return base + ADDR_WIDTH'(off);
  endfunction

  always_comb begin
    chk_code = 2'd0;
    if (dim_bad(a_m_q) || dim_bad(a_n_q) ||
        ((op_q == OP_ADD || op_q == OP_MUL) && (dim_bad(b_m_q) || dim_bad(b_n_q))))
      chk_code = 2'd1;
    else if (op_q == OP_ADD && (a_m_q != b_m_q || a_n_q != b_n_q))
      chk_code = 2'd2;
    else if (op_q == OP_MUL && a_n_q != b_m_q)
      chk_code = 2'd2;
  end

  assign reads = (op_q == OP_MUL) ? {1'b0, a_n_q, 1'b0} : (op_q == OP_ADD) ? 6'd2 : 6'd1;

  // MUL interleaves A[r][k] (even reads) and B[k][c] (odd reads) with k = cnt/2
  always_comb begin
    rd_addr_c = addr_of(a_base_q, row, a_n_q, col);
    case (op_q)
      OP_ADD:  rd_addr_c = cnt[0] ? addr_of(b_base_q, row, b_n_q, col)
                                  : addr_of(a_base_q, row, a_n_q, col);
      OP_MUL:  rd_addr_c = cnt[0] ? addr_of(b_base_q, cnt[4:1], b_n_q, col)
                                  : addr_of(a_base_q, row, a_n_q, cnt[4:1]);
      OP_TRN:  rd_addr_c = addr_of(a_base_q, col, a_n_q, row);
      default: rd_addr_c = addr_of(a_base_q, row, a_n_q, col);
    endcase
  end

  assign data_ext = ACC_WIDTH'($signed(mem_rd_data));
  assign mul_prod = PW'(a_hold) * PW'($signed(mem_rd_data));
  assign scl_prod = PW'($signed(mem_rd_data)) * PW'(scalar_q);

  always_comb begin
    state_nxt   = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CHECK;
      S_CHECK:  begin
        busy      = 1'b1;
        state_nxt = (chk_code != 2'd0) ? S_ERROR : S_FETCH;
      end
      S_FETCH:  begin
        busy = 1'b1;
        if (cnt < reads) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = rd_addr_c;
        end
        if (cnt == reads) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = acc;
        res_last  = (row == res_m - 4'd1) && (col == res_n - 4'd1);
        if (res_ready) state_nxt = res_last ? S_DONE : S_FETCH;
      end
      S_DONE, S_ERROR: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      a_m_q      <= '0;
      a_n_q      <= '0;
      b_m_q      <= '0;
      b_n_q      <= '0;
      scalar_q   <= '0;
      res_m      <= '0;
      res_n      <= '0;
      error_code <= '0;
      row        <= '0;
      col        <= '0;
      cnt        <= '0;
      acc        <= '0;
      a_hold     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_CHECK) begin
        op_q       <= op;
        a_base_q   <= a_base;
        b_base_q   <= b_base;
        a_m_q      <= a_m;
        a_n_q      <= a_n;
        b_m_q      <= b_m;
        b_n_q      <= b_n;
        scalar_q   <= scalar;
        error_code <= 2'd0;
      end
      if (state == S_CHECK) begin
        error_code <= chk_code;
        res_m      <= (op_q == OP_TRN) ? a_n_q : a_m_q;
        res_n      <= (op_q == OP_MUL) ? b_n_q : (op_q == OP_TRN) ? a_m_q : a_n_q;
        row        <= '0;
        col        <= '0;
      end else if (state == S_OUTPUT && state_nxt == S_FETCH) begin
        if (col == res_n - 4'd1) begin
          col <= '0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
      cnt <= (state == S_FETCH && state_nxt == S_FETCH) ? cnt + 6'd1 : 6'd0;
      // Read data lags its strobe by one cycle, so cnt-1 is the read being consumed
      if (state_nxt == S_IDLE || (state != S_FETCH && state_nxt == S_FETCH)) begin
        acc <= '0;
      end else if (state == S_FETCH && cnt != 6'd0) begin
        case (op_q)
          OP_ADD:  acc <= acc + data_ext;
          OP_MUL:  if (!cnt[0]) acc <= acc + ACC_WIDTH'(mul_prod);
                   else a_hold <= $signed(mem_rd_data);
          OP_TRN:  acc <= data_ext;
          default: acc <= ACC_WIDTH'(scl_prod);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_compute_engine.sv
// tb/tb_matrix_compute_engine.sv - self-checking bench for matrix_compute_engine
// Result matrices and read sequences come from a plain arithmetic model over the bench memory.
module tb_matrix_compute_engine;
  localparam int EW  = 8;
  localparam int AW  = 11;
  localparam int ACW = 20;

  logic           clk = 1'b0;
  logic           rst_n, start, abort, res_ready;
  logic [1:0]     op;
  logic [AW-1:0]  a_base, b_base;
  logic [3:0]     a_m, a_n, b_m, b_n;
  logic [EW-1:0]  scalar;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_rd_addr;
  logic [EW-1:0]  mem_rd_data = '0;
  logic           res_valid, res_last, busy, done;
  logic [ACW-1:0] res_data;
  logic [3:0]     res_m, res_n;
  logic [1:0]     error_code;

  matrix_compute_engine #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_DIM(5), .ACC_WIDTH(ACW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .a_base(a_base), .b_base(b_base), .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n),
    .scalar(scalar), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .res_m(res_m), .res_n(res_n),
    .busy(busy), .done(done), .error_code(error_code)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  logic [ACW-1:0] exp_data[$];
  bit             exp_last[$];
  logic [AW-1:0]  exp_addr[$];
  int checks = 0, failures = 0;
  int exp_rm, exp_rn, exp_lat, exp_err;
  int cyc = 0, start_cyc = 0, first_rd_cyc = 0, last_hs_cyc = 0;
  int n_acc = 0, stall = 0, stall_obs = 0;
  bit bp_on = 0, prev_valid = 0, prev_rd = 0, first_rd_seen = 0, saw_valid = 0, saw_done = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int rd(input int a);
    logic signed [EW-1:0] v;
    v = mem[a & ((1 << AW) - 1)];
    return int'(v);
  endfunction

  task automatic push_addr(input int a);
    exp_addr.push_back(a[AW-1:0]);
  endtask

  task automatic build_model(input int o, input int ab, input int bb, input int am,
                             input int an, input int bn, input int sc);
    int v, ia, ib;
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    exp_rm  = (o == 2) ? an : am;
    exp_rn  = (o == 1) ? bn : (o == 2) ? am : an;
    exp_lat = (o == 0) ? 3 : (o == 1) ? 2 * an + 1 : 2;
    for (int r = 0; r < exp_rm; r++)
      for (int c = 0; c < exp_rn; c++) begin
        v = 0;
        case (o)
          0: begin
            ia = ab + r * an + c; ib = bb + r * bn + c;
            push_addr(ia); push_addr(ib); v = rd(ia) + rd(ib);
          end
          1: for (int k = 0; k < an; k++) begin
            ia = ab + r * an + k; ib = bb + k * bn + c;
            push_addr(ia); push_addr(ib); v += rd(ia) * rd(ib);
          end
          2: begin ia = ab + c * an + r; push_addr(ia); v = rd(ia); end
          default: begin ia = ab + r * an + c; push_addr(ia); v = rd(ia) * sc; end
        endcase
        exp_data.push_back(v[ACW-1:0]);
        exp_last.push_back(r == exp_rm - 1 && c == exp_rn - 1);
      end
  endtask

  task automatic pin(input string nm, input int idx, input int v);
    logic [ACW-1:0] t;
    t = v[ACW-1:0];
    chk(nm, exp_data[idx], t);
  endtask

  // Backpressure: hold res_ready low for 5 valid cycles on the second element
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_on && n_acc == 1 && res_valid && stall < 5) begin
        res_ready = 1'b0;
        stall++;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy) start_cyc = cyc;
      if (mem_rd_en) begin
        if (!prev_rd) first_rd_cyc = cyc;
        if (!prev_rd && !first_rd_seen) begin
          chk("first_read_latency", cyc - start_cyc, 2);
          first_rd_seen = 1;
        end
        if (exp_addr.size() == 0) chk("extra_read", mem_rd_addr, -1);
        else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
      end
      if (res_valid) begin
        saw_valid = 1;
        if (!res_ready) stall_obs++;
        if (!prev_valid) chk("valid_latency", cyc - first_rd_cyc, exp_lat);
        if (exp_data.size() == 0) chk("unexpected_valid", res_data, -1);
        else begin
          chk("res_data", res_data, exp_data[0]);
          chk("res_last", res_last, exp_last[0]);
          if (res_ready && !abort) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
            n_acc++;
            last_hs_cyc = cyc;
          end
        end
      end
      if (done) begin
        saw_done = 1;
        if (exp_err != 0) chk("error_done_cycle", cyc - start_cyc, 2);
        else chk("done_cycle", cyc - last_hs_cyc, 1);
        chk("busy_with_done", busy, 0);
      end
      prev_valid = res_valid;
      prev_rd    = mem_rd_en;
    end
  end

  task automatic issue(input int o, input int ab, input int bb, input int am, input int an,
                       input int bm, input int bn, input int sc, input int e, input bit bp);
    exp_err = e;
    build_model(o, ab, bb, am, an, bn, sc);
    if (e != 0) begin exp_data.delete(); exp_last.delete(); exp_addr.delete(); end
    n_acc = 0; stall = 0; stall_obs = 0; bp_on = bp;
    first_rd_seen = 0; saw_valid = 0; saw_done = 0;
    @(posedge clk); #1;
    op = 2'(o); a_base = AW'(ab); b_base = AW'(bb);
    a_m = 4'(am); a_n = 4'(an); b_m = 4'(bm); b_n = 4'(bn); scalar = EW'(sc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = ~op; a_base = ~a_base; b_base = ~b_base; a_m = 4'hf; a_n = 4'h0;
    b_m = 4'h0; b_n = 4'hf; scalar = ~scalar;
  endtask

  task automatic run_op(input int o, input int ab, input int bb, input int am, input int an,
                        input int bm, input int bn, input int sc, input int e, input bit bp);
    issue(o, ab, bb, am, an, bm, bn, sc, e, bp);
    for (int i = 0; i < 2000 && !saw_done; i++) @(posedge clk);
    #1;
    chk("done_seen", saw_done, 1);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("error_code", error_code, e);
    chk("any_valid", saw_valid, e == 0);
    chk("reads_left", exp_addr.size(), 0);
    chk("results_left", exp_data.size(), 0);
    if (e == 0) begin
      chk("res_m", res_m, exp_rm);
      chk("res_n", res_n, exp_rn);
    end
    if (bp) chk("stall_cycles", stall_obs, 5);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a_base = '0; b_base = '0;
    a_m = '0; a_n = '0; b_m = '0; b_n = '0; scalar = '0; exp_err = 0; exp_lat = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = EW'($urandom);
    for (int i = 0; i < 4; i++) begin mem[16 + i] = EW'(i + 1); mem[32 + i] = EW'(i + 5); end
    for (int i = 0; i < 6; i++) begin mem[48 + i] = EW'(i + 1); mem[64 + i] = EW'(i + 7); end
    mem[2046] = 8'h80; mem[2047] = 8'h7f; mem[0] = 8'h05; mem[1] = 8'hff;
    mem[256] = 8'h80; mem[300] = 8'h80;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_data", res_data, 0);
    chk("rst_error", error_code, 0);
    chk("rst_res_m", res_m, 0);
    rst_n = 1'b1;

    build_model(0, 16, 32, 2, 2, 2, 0);
    pin("model_add0", 0, 6); pin("model_add1", 1, 8); pin("model_add2", 2, 10); pin("model_add3", 3, 12);
    run_op(0, 16, 32, 2, 2, 2, 2, 0, 0, 0);

    build_model(1, 48, 64, 2, 3, 2, 0);
    pin("model_mul0", 0, 58); pin("model_mul1", 1, 64); pin("model_mul2", 2, 139); pin("model_mul3", 3, 154);
    chk("model_mul_lat", exp_lat, 7);
    run_op(1, 48, 64, 2, 3, 3, 2, 0, 0, 0);

    build_model(2, 48, 0, 2, 3, 0, 0);
    pin("model_trn0", 0, 1); pin("model_trn1", 1, 4); pin("model_trn2", 2, 2);
    pin("model_trn3", 3, 5); pin("model_trn4", 4, 3); pin("model_trn5", 5, 6);
    chk("model_trn_rm", exp_rm, 3);
    run_op(2, 48, 0, 2, 3, 0, 0, 0, 0, 0);

    build_model(3, 2046, 0, 2, 2, 0, -3);
    pin("model_scl0", 0, 384); pin("model_scl1", 1, -381); pin("model_scl2", 2, -15); pin("model_scl3", 3, 3);
    run_op(3, 2046, 0, 2, 2, 0, 0, -3, 0, 0);

    run_op(0, 16, 32, 2, 2, 2, 3, 0, 2, 0);
    run_op(2, 48, 0, 0, 3, 0, 0, 0, 1, 0);
    run_op(0, 256, 300, 5, 5, 5, 5, 0, 0, 0);
    run_op(0, 16, 32, 6, 2, 2, 3, 0, 1, 0);
    run_op(1, 48, 64, 2, 3, 2, 2, 0, 2, 0);
    run_op(1, 256, 300, 5, 5, 5, 5, 0, 0, 0);
    run_op(1, 48, 64, 2, 3, 3, 2, 0, 0, 1);

    issue(1, 48, 64, 2, 3, 3, 2, 0, 0, 0);
    for (int i = 0; i < 100 && n_acc < 2; i++) @(posedge clk);
    #1;
    for (int i = 0; i < 20 && !mem_rd_en; i++) begin @(posedge clk); #1; end
    chk("abort_in_fetch", mem_rd_en, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_done", saw_done, 0);
    run_op(1, 48, 64, 2, 3, 3, 2, 0, 0, 0);

    issue(1, 256, 300, 5, 5, 5, 5, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_res_m", res_m, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(2, 48, 0, 2, 3, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
